ifft_iter: RTL and testbench

Iterative radix-2 decimation-in-time inverse FFT: the return path for the fully parallel forward `fft`. It accepts one frequency-domain frame of N complex samples over a valid/ready stream and computes the inverse transform in place with a single time-shared butterfly. It then streams the N time-domain samples out in natural order. The 1/N normalisation is applied as a divide-by-2 per stage, so an `fft` → `ifft_iter` round trip is unity gain.

---
 rtl/ifft_iter.sv | 152 +++++++++++++++
 tb/tb_ifft_iter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ifft_iter.sv
// rtl/ifft_iter.sv - iterative radix-2 DIT inverse FFT with a single time-shared butterfly
// Frames load bit-reversed, transform in place at 1/2 gain per stage, and unload in natural order.
module ifft_iter #(
  parameter int N      = 16,
  parameter int W      = 16,
  parameter int STAGES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_real,
  input  logic signed [W-1:0] s_im,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] m_real,
  output logic signed [W-1:0] m_im,
  output logic                m_last,
  output logic                busy
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PW = W + 17;
  localparam int RW = W + 3;
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (W - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = -RW'(2 ** (W - 1));

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t              state;
  logic [STAGES-1:0]   in_cnt;
  logic [STAGES-1:0]   out_cnt;
  logic [STAGES-2:0]   k;
  logic [SW-1:0]       s;
  logic signed [W-1:0] mem_re [N];
  logic signed [W-1:0] mem_im [N];

  function automatic logic [STAGES-1:0] bitrev(input logic [STAGES-1:0] v);
    logic [STAGES-1:0] r;
    for (int i = 0; i < STAGES; i++) r[i] = v[STAGES-1-i];
    return r;
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [RW-1:0] v);
    if (v > MAXV) return MAXV[W-1:0];
    if (v < MINV) return MINV[W-1:0];
    return v[W-1:0];
  endfunction

  // Butterfly addressing for stage s, pair k
  logic [STAGES-1:0] kk, mask, bsel, ia, ib, tfull;
  logic [2:0]        tix;
  always_comb begin
    kk    = {1'b0, k};
    mask  = (STAGES'(1) << s) - STAGES'(1);
    bsel  = kk & mask;
    ia    = ((kk >> s) << ((SW+1)'(s) + (SW+1)'(1))) | bsel;
    ib    = ia | (STAGES'(1) << s);
    tfull = bsel << (STAGES - 1 - int'(s));
    tix   = 3'((32'(tfull) * 16) / N);
  end

  // Conjugated forward twiddles, Q8.8
  logic signed [9:0] w_re, w_im;
  always_comb begin
    w_re = 10'sd256;
    w_im = 10'sd0;
    case (tix)
      3'd0: begin w_re = 10'sd256;  w_im = 10'sd0;   end
      3'd1: begin w_re = 10'sd236;  w_im = 10'sd98;  end
      3'd2: begin w_re = 10'sd181;  w_im = 10'sd181; end
      3'd3: begin w_re = 10'sd98;   w_im = 10'sd236; end
      3'd4: begin w_re = 10'sd0;    w_im = 10'sd256; end
      3'd5: begin w_re = -10'sd98;  w_im = 10'sd236; end
      3'd6: begin w_re = -10'sd181; w_im = 10'sd181; end
      3'd7: begin w_re = -10'sd236; w_im = 10'sd98;  end
      default: ;
    endcase
  end

  logic signed [W-1:0]  a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] pf_re, pf_im;
  logic signed [RW-1:0] p_re, p_im;
  logic signed [W-1:0]  na_re, na_im, nb_re, nb_im;
  always_comb begin
    a_re  = mem_re[ia];
    a_im  = mem_im[ia];
    b_re  = mem_re[ib];
    b_im  = mem_im[ib];
    pf_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    pf_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    p_re  = RW'(pf_re >>> 8);
    p_im  = RW'(pf_im >>> 8);
    na_re = sat((RW'(a_re) + p_re) >>> 1);
    na_im = sat((RW'(a_im) + p_im) >>> 1);
    nb_re = sat((RW'(a_re) - p_re) >>> 1);
    nb_im = sat((RW'(a_im) - p_im) >>> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      in_cnt  <= '0;
      out_cnt <= '0;
      k       <= '0;
      s       <= '0;
    end else begin
      case (state)
        LOAD: if (s_valid) begin
          in_cnt <= in_cnt + 1'b1;
          if (in_cnt == '1) state <= COMPUTE;
        end
        COMPUTE: begin
          k <= k + 1'b1;
          if (k == '1) begin
            s <= s + 1'b1;
            if (s == SW'(STAGES - 1)) begin
              s     <= '0;
              state <= UNLOAD;
            end
          end
        end
        UNLOAD: if (m_ready) begin
          out_cnt <= out_cnt + 1'b1;
          if (out_cnt == '1) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Register file is not reset; a new frame overwrites every entry before use
  always_ff @(posedge clk) begin
    if (state == LOAD && s_valid) begin
      mem_re[bitrev(in_cnt)] <= s_real;
      mem_im[bitrev(in_cnt)] <= s_im;
    end else if (state == COMPUTE) begin
      mem_re[ia] <= na_re;
      mem_im[ia] <= na_im;
      mem_re[ib] <= nb_re;
      mem_im[ib] <= nb_im;
    end
  end

  assign s_ready = (state == LOAD);
  assign m_valid = (state == UNLOAD);
  assign busy    = (state != LOAD);
  assign m_last  = (state == UNLOAD) && (out_cnt == '1);
  assign m_real  = mem_re[out_cnt];
  assign m_im    = mem_im[out_cnt];

endmodule

// File: tb/tb_ifft_iter.sv
// tb/tb_ifft_iter.sv - scoreboard bench for ifft_iter
// Frames are queued with their expected time-domain samples and matched as outputs are accepted.
module tb_ifft_iter;
  localparam int N = 16;
  localparam int W = 16;
  localparam int STAGES = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic signed [W-1:0] s_real, s_im, m_real, m_im;

  ifft_iter #(.N(N), .W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_im(s_im), .m_valid(m_valid), .m_ready(m_ready),
    .m_real(m_real), .m_im(m_im), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int re; int im; bit last; int tol;} exp_t;
  exp_t sbq[$];

  int total = 0, bad = 0, stall_bad = 0, busy_acc = 0, lat;
  int bank_re[4][N], bank_im[4][N], exp_re[4][N], exp_im[4][N], bank_tol[4];

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int expv, input int tol);
    int d;
    d = obs - expv;
    if (d < 0) d = -d;
    total++;
    assert ((d <= tol) === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
    end
  endtask

  task automatic push_frame(input int idx);
    for (int n = 0; n < N; n++)
      sbq.push_back('{exp_re[idx][n], exp_im[idx][n], (n == N - 1), bank_tol[idx]});
  endtask

  task automatic drive_frame(input int idx, input bit rnd);
    int i = 0, cyc = 0;
    while (i < N && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (busy && s_ready) busy_acc++;
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_real  = W'(bank_re[idx][i]);
      s_im    = W'(bank_im[idx][i]);
      if (s_valid && s_ready) i++;
    end
    check($sformatf("drive_accepts[%0d]", idx), i, N);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic collect(input int nsamp, input bit rnd);
    int got = 0, cyc = 0;
    bit held = 0;
    logic signed [W-1:0] hr, hi;
    logic hl;
    exp_t e;
    while (got < nsamp && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (held && m_valid && (m_real !== hr || m_im !== hi || m_last !== hl)) stall_bad++;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sbq.pop_front();
          check_tol($sformatf("re[%0d]", got), int'(m_real), e.re, e.tol);
          check_tol($sformatf("im[%0d]", got), int'(m_im), e.im, e.tol);
          check($sformatf("last[%0d]", got), m_last, e.last);
        end
        got++;
        held = 0;
      end else begin
        held = m_valid;
        hr = m_real;
        hi = m_im;
        hl = m_last;
      end
    end
    check("collect_count", got, nsamp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    real sr, si, ang, pi;
    pi = 3.14159265358979;
    s_valid = 0; m_ready = 0; s_real = '0; s_im = '0;

    for (int f = 0; f < 4; f++)
      for (int n = 0; n < N; n++) begin
        bank_re[f][n] = 0; bank_im[f][n] = 0; exp_re[f][n] = 0; exp_im[f][n] = 0;
      end
    // 0: impulse, 1: DC, 2: tone at bin 4, 3: random round trip
    bank_re[0][0] = 256;
    for (int n = 0; n < N; n++) exp_re[0][n] = 16;
    bank_tol[0] = 0;
    for (int n = 0; n < N; n++) bank_re[1][n] = 256;
    exp_re[1][0] = 256;
    bank_tol[1] = 0;
    bank_re[2][4] = 256;
    for (int n = 0; n < N; n++) begin
      case (n % 4)
        0: exp_re[2][n] = 16;
        1: exp_im[2][n] = 16;
        2: exp_re[2][n] = -16;
        default: exp_im[2][n] = -16;
      endcase
    end
    bank_tol[2] = 1;
    for (int n = 0; n < N; n++) begin
      exp_re[3][n] = int'($urandom_range(0, 200)) - 100;
      exp_im[3][n] = int'($urandom_range(0, 200)) - 100;
    end
    for (int kx = 0; kx < N; kx++) begin
      sr = 0.0; si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = -2.0 * pi * real'(kx * n) / real'(N);
        sr += real'(exp_re[3][n]) * $cos(ang) - real'(exp_im[3][n]) * $sin(ang);
        si += real'(exp_re[3][n]) * $sin(ang) + real'(exp_im[3][n]) * $cos(ang);
      end
      bank_re[3][kx] = $rtoi(sr + ((sr >= 0.0) ? 0.5 : -0.5));
      bank_im[3][kx] = $rtoi(si + ((si >= 0.0) ? 0.5 : -0.5));
    end
    bank_tol[3] = STAGES;

    #2 rst = 1'b1;
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_last", m_last, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Impulse with latency and handshake-edge checks
    push_frame(0);
    drive_frame(0, 0);
    check("s_ready_fall", s_ready, 0);
    check("busy_compute", busy, 1);
    lat = 0;
    while (!m_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, STAGES * N / 2);
    collect(N, 0);
    check("s_ready_rise", s_ready, 1);
    check("busy_idle", busy, 0);

    push_frame(1);
    drive_frame(1, 0);
    collect(N, 0);

    push_frame(2);
    drive_frame(2, 0);
    collect(N, 0);

    // Three back-to-back frames under random stalls on both sides
    push_frame(0);
    push_frame(1);
    push_frame(2);
    fork
      begin
        drive_frame(0, 1);
        drive_frame(1, 1);
        drive_frame(2, 1);
      end
      collect(3 * N, 1);
    join
    check("stall_hold", stall_bad, 0);
    check("accept_while_busy", busy_acc, 0);

    // Abandon a frame mid-compute
    m_ready = 1'b0;
    drive_frame(1, 0);
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_s_ready", s_ready, 1);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    push_frame(0);
    drive_frame(0, 0);
    collect(N, 0);

    push_frame(3);
    drive_frame(3, 0);
    collect(N, 0);

    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
